// File: rtl/led_pkg.sv
// Shared types and default 50 MHz timing for the LED chain output path.
package led_pkg;

   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } color_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_LATCH
   } ser_state_t;

   localparam int DEF_T0H_CYCLES   = 20;
   localparam int DEF_T1H_CYCLES   = 40;
   localparam int DEF_BIT_CYCLES   = 63;
   localparam int DEF_RESET_CYCLES = 15000;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// One WS2812 bit period: a start pulse launches a BIT_CYCLES-long slot whose
// high time depends on the bit value; bit_end flags the last cycle of the slot.
module ws2812_bit_timer import led_pkg::*; #(
   parameter int T0H_CYCLES = DEF_T0H_CYCLES,
   parameter int T1H_CYCLES = DEF_T1H_CYCLES,
   parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic bit_val,
   output logic wave,
   output logic bit_end
);

   localparam int CW = $clog2(BIT_CYCLES + 1);
   localparam logic [CW-1:0] T0H_W  = CW'(T0H_CYCLES);
   localparam logic [CW-1:0] T1H_W  = CW'(T1H_CYCLES);
   localparam logic [CW-1:0] LAST_W = CW'(BIT_CYCLES - 1);

   logic [CW-1:0] cyc_q, cyc_d;
   logic [CW-1:0] cyc_inc;
   logic [CW-1:0] thr;
   logic          bit_q, bit_d;
   logic          run_q, run_d;
   logic          wave_q, wave_d;

   // wave_d is the level for the cycle the counter moves into, so the
   // registered line lines up with cyc_q without an extra cycle of lag.
   always_comb begin
      cyc_inc = cyc_q + 1'b1;
      thr     = bit_q ? T1H_W : T0H_W;
      bit_end = run_q && (cyc_q == LAST_W);
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      run_d   = run_q;
      wave_d  = 1'b0;
      if (start) begin
         cyc_d  = '0;
         bit_d  = bit_val;
         run_d  = 1'b1;
         wave_d = 1'b1;
      end else if (bit_end) begin
         cyc_d = '0;
         run_d = 1'b0;
      end else if (run_q) begin
         cyc_d  = cyc_inc;
         wave_d = (cyc_inc < thr);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q  <= '0;
         bit_q  <= 1'b0;
         run_q  <= 1'b0;
         wave_q <= 1'b0;
      end else begin
         cyc_q  <= cyc_d;
         bit_q  <= bit_d;
         run_q  <= run_d;
         wave_q <= wave_d;
      end
   end

   assign wave = wave_q;

endmodule

// File: rtl/ws2812_serializer.sv
// Streams 24-bit pixels onto the WS2812 single-wire line and closes each
// frame with a low latch period followed by a frame_done pulse.
//
//   state   | meaning
//   S_IDLE  | line low, ready for the first pixel of a frame
//   S_SEND  | shifting out pixel bits, bit 23 first
//   S_LATCH | line held low for RESET_CYCLES to latch the chain
module ws2812_serializer import led_pkg::*; #(
   parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
   parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
   parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pixel_valid,
   output logic        pixel_ready,
   input  logic [23:0] pixel_color,
   input  logic        pixel_last,
   output logic        dout,
   output logic        busy,
   output logic        frame_done,
   output logic        underrun
);

   if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
         T1H_CYCLES < BIT_CYCLES && RESET_CYCLES >= 1)) begin : g_bad_timing
      $error("ws2812_serializer: illegal timing parameters");
   end

   localparam int LW = $clog2(imax(BIT_CYCLES, RESET_CYCLES) + 1);
   localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);

   ser_state_t    state_q, state_d;
   color_t        shift_q, shift_d;
   logic [4:0]    bit_idx_q, bit_idx_d;
   logic          last_q, last_d;
   logic [LW-1:0] latch_cyc_q, latch_cyc_d;
   logic          frame_done_q, frame_done_d;
   logic          underrun_q, underrun_d;

   logic pix_end;
   logic xfer;
   logic start;
   logic bit_end;
   logic wave;

   ws2812_bit_timer #(
      .T0H_CYCLES (T0H_CYCLES),
      .T1H_CYCLES (T1H_CYCLES),
      .BIT_CYCLES (BIT_CYCLES)
   ) u_bit_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bit_val (shift_d[23]),
      .wave    (wave),
      .bit_end (bit_end)
   );

   always_comb begin
      pix_end      = (state_q == S_SEND) && bit_end && (bit_idx_q == 5'd0);
      pixel_ready  = !rst && ((state_q == S_IDLE) || (pix_end && !last_q));
      xfer         = pixel_valid && pixel_ready;
      busy         = (state_q != S_IDLE);
      state_d      = state_q;
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      last_d       = last_q;
      latch_cyc_d  = latch_cyc_q;
      underrun_d   = 1'b0;
      start        = 1'b0;
      case (state_q)
         S_IDLE: ;
         S_SEND: begin
            if (bit_end && !pix_end) begin
               // rotate rather than shift so the stale top bit stays consumed
               shift_d   = color_t'({shift_q[22:0], shift_q[23]});
               bit_idx_d = bit_idx_q - 5'd1;
               start     = 1'b1;
            end else if (pix_end && !xfer) begin
               state_d     = S_LATCH;
               latch_cyc_d = '0;
               underrun_d  = !last_q;
            end
         end
         S_LATCH: begin
            if (latch_cyc_q == LATCH_LAST) begin
               state_d     = S_IDLE;
               latch_cyc_d = '0;
            end else begin
               latch_cyc_d = latch_cyc_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A transfer can only happen in IDLE or on the final cycle of a non-last pixel.
      if (xfer) begin
         state_d   = S_SEND;
         shift_d   = color_t'(pixel_color);
         last_d    = pixel_last;
         bit_idx_d = 5'd23;
         start     = 1'b1;
      end
      frame_done_d = (state_d == S_LATCH) && (latch_cyc_d == LATCH_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         bit_idx_q    <= '0;
         last_q       <= 1'b0;
         latch_cyc_q  <= '0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         last_q       <= last_d;
         latch_cyc_q  <= latch_cyc_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
      end
   end

   assign dout       = wave;
   assign frame_done = frame_done_q;
   assign underrun   = underrun_q;

endmodule
